// File: rtl/if_stage_prefetch_pkg.sv
// Shared types and constants for the prefetching instruction-fetch stage.
// Entry layouts of the in-flight and instruction-buffer queues live here.
package if_stage_prefetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam int          IF_ID_BUS_W      = 64;
  localparam int          REDIRECT_BUS_W   = 33;
  localparam logic [1:0]  SRAM_SIZE_WORD   = 2'b10;
  localparam logic [3:0]  SRAM_WSTRB_NONE  = 4'b0000;

  typedef struct packed {
    logic        stale;
    logic [31:0] pc;
  } inflight_entry_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ibuf_entry_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } redirect_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_stage_prefetch_sync_fifo.sv
// Small synchronous FIFO with flush; head word is readable combinationally
// so the fetch stage can present it without an extra cycle.
module if_stage_prefetch_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign dout    = mem_reg[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_reg[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/if_stage_prefetch.sv
// Pre-IF + IF stage: keeps several fetches in flight on the SRAM-like inst bus
// and queues returned words for ID; redirects discard all younger work.
module if_stage_prefetch
  import if_stage_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [1:0]                inst_sram_size,
  output logic [3:0]                inst_sram_wstrb,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata,
  input  logic                      id_allowin,
  input  logic [REDIRECT_BUS_W-1:0] id_to_if_bus,
  input  logic [REDIRECT_BUS_W-1:0] wb_to_if_bus,
  output logic                      if_to_id_valid,
  output logic [IF_ID_BUS_W-1:0]    if_to_id_bus
);

  localparam int INF_CNT_W  = cnt_width(MAX_OUTSTANDING);
  localparam int IBUF_CNT_W = cnt_width(IBUF_DEPTH);
  localparam int SUM_W      = IBUF_CNT_W + 1;

  redirect_t       id_br, wb_flush;
  logic            redirect;
  logic [31:0]     redirect_target;

  logic            pend_reg, pend_next;
  logic            pend_stale_reg, pend_stale_next;
  logic [31:0]     fetch_pc_reg, fetch_pc_next;
  logic [31:0]     req_addr_reg, req_addr_next;
  logic [INF_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  inflight_entry_t inflight_din, inflight_head;
  logic            inflight_full, inflight_empty;
  logic [INF_CNT_W-1:0] inflight_cnt, inflight_after;
  ibuf_entry_t     ibuf_din, ibuf_head;
  logic            ibuf_full, ibuf_empty, ibuf_push, ibuf_pop;
  logic [IBUF_CNT_W-1:0] ibuf_cnt;

  logic [SUM_W-1:0] occupancy;
  logic            credit_ok, issue_ok, accept, drop_word;

  assign id_br           = id_to_if_bus;
  assign wb_flush        = wb_to_if_bus;
  assign redirect        = wb_flush.taken | id_br.taken;
  assign redirect_target = wb_flush.taken ? wb_flush.target : id_br.target;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SRAM_SIZE_WORD;
  assign inst_sram_wstrb = SRAM_WSTRB_NONE;
  assign inst_sram_wdata = 32'h0;

  // Every issued request reserves an ibuf slot, so a returning word always fits.
  assign occupancy     = SUM_W'(inflight_cnt) + SUM_W'(ibuf_cnt);
  assign credit_ok     = ~inflight_full && (occupancy < SUM_W'(IBUF_DEPTH));
  assign issue_ok      = ~redirect & ~pend_reg & credit_ok;
  assign inst_sram_req = ~reset & (pend_reg | issue_ok);
  assign inst_sram_addr = req_addr_reg;
  assign accept        = inst_sram_req & inst_sram_addr_ok;

  assign inflight_din.stale = pend_stale_reg | redirect;
  assign inflight_din.pc    = req_addr_reg;

  // Entries in flight at a redirect are counted in drop_cnt; later stale pushes carry their own bit.
  assign drop_word = redirect | (drop_cnt_reg != '0) | inflight_head.stale;
  assign ibuf_push = inst_sram_data_ok & ~drop_word;
  assign ibuf_din.inst = inst_sram_rdata;
  assign ibuf_din.pc   = inflight_head.pc;

  assign if_to_id_valid = ~ibuf_empty & ~redirect;
  assign if_to_id_bus   = ibuf_head;
  assign ibuf_pop       = if_to_id_valid & id_allowin;

  assign inflight_after = inflight_cnt + INF_CNT_W'(accept) - INF_CNT_W'(inst_sram_data_ok);

  always_comb begin
    pend_next       = inst_sram_req & ~inst_sram_addr_ok;
    pend_stale_next = pend_next & (pend_stale_reg | redirect);
    fetch_pc_next   = fetch_pc_reg;
    if (redirect)
      fetch_pc_next = redirect_target;
    else if (accept && !pend_stale_reg)
      fetch_pc_next = fetch_pc_reg + 32'd4;
    req_addr_next = pend_next ? req_addr_reg : fetch_pc_next;
    drop_cnt_next = drop_cnt_reg;
    if (redirect)
      drop_cnt_next = inflight_after;
    else if (inst_sram_data_ok && drop_cnt_reg != '0)
      drop_cnt_next = drop_cnt_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg       <= 1'b0;
      pend_stale_reg <= 1'b0;
      fetch_pc_reg   <= RESET_PC;
      req_addr_reg   <= RESET_PC;
      drop_cnt_reg   <= '0;
    end else begin
      pend_reg       <= pend_next;
      pend_stale_reg <= pend_stale_next;
      fetch_pc_reg   <= fetch_pc_next;
      req_addr_reg   <= req_addr_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  if_stage_prefetch_sync_fifo #(
    .WIDTH ($bits(inflight_entry_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (inst_sram_data_ok),
    .clear (1'b0),
    .din   (inflight_din),
    .dout  (inflight_head),
    .full  (inflight_full),
    .empty (inflight_empty),
    .count (inflight_cnt)
  );

  if_stage_prefetch_sync_fifo #(
    .WIDTH ($bits(ibuf_entry_t)),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .push  (ibuf_push),
    .pop   (ibuf_pop),
    .clear (redirect),
    .din   (ibuf_din),
    .dout  (ibuf_head),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (ibuf_cnt)
  );

  assert property (@(posedge clk) disable iff (reset) inst_sram_data_ok |-> !inflight_empty);
  assert property (@(posedge clk) disable iff (reset) ibuf_push |-> !ibuf_full);

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: SRAM-like memory model with configurable handshake
// latency, an independent in-order PC reference for ID, and directed scenarios.
module tb_if_stage_prefetch;

  localparam logic [31:0] RST_PC  = 32'h1c000000;
  localparam int          MAX_OUT = 2;
  localparam int          IBUF_D  = 4;

  logic        clk, reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        id_allowin;
  logic [32:0] id_to_if_bus, wb_to_if_bus;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;

  if_stage_prefetch #(
    .RESET_PC        (RST_PC),
    .IBUF_DEPTH      (IBUF_D),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (req),
    .inst_sram_wr      (wr),
    .inst_sram_size    (size),
    .inst_sram_wstrb   (wstrb),
    .inst_sram_addr    (addr),
    .inst_sram_wdata   (wdata),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata),
    .id_allowin        (id_allowin),
    .id_to_if_bus      (id_to_if_bus),
    .wb_to_if_bus      (wb_to_if_bus),
    .if_to_id_valid    (if_to_id_valid),
    .if_to_id_bus      (if_to_id_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkinst(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a0f0f;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          ready;
  } resp_t;
  resp_t mq[$];
  int  cyc, wait_cnt, addr_delay, lat;
  bit  rand_mode;
  bit  rst_seen, acc_seen, dok_seen, req_seen;
  logic [31:0] acc_addr;

  always_comb addr_ok = req && (wait_cnt >= addr_delay);

  initial begin
    data_ok = 1'b0;
    rdata = 32'h0;
    wait_cnt = 0;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_seen) begin
        mq.delete();
        wait_cnt = 0;
      end else begin
        if (dok_seen && mq.size() > 0) void'(mq.pop_front());
        if (acc_seen) begin
          mq.push_back('{acc_addr, cyc + (rand_mode ? int'($urandom_range(1, 4)) : lat)});
          wait_cnt = 0;
          if (rand_mode) addr_delay = $urandom_range(0, 3);
        end else if (req_seen) begin
          wait_cnt++;
        end
      end
      cyc++;
      if (mq.size() > 0 && mq[0].ready <= cyc) begin
        data_ok = 1'b1;
        rdata = mkinst(mq[0].addr);
      end else begin
        data_ok = 1'b0;
        rdata = 32'h0;
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  logic [31:0] exp_pc, prev_addr, first_pc;
  bit  prev_pend, want_first;
  int  infl, n_acc, n_dok, n_id;

  always @(negedge clk) begin
    rst_seen = reset;
    req_seen = req;
    acc_seen = req && addr_ok;
    acc_addr = addr;
    dok_seen = data_ok;
    if (reset) begin
      exp_pc = RST_PC;
      infl = 0; n_acc = 0; n_dok = 0; n_id = 0;
      prev_pend = 1'b0;
      want_first = 1'b0;
    end else begin
      if (prev_pend) begin
        check("bus_hold_req", 32'(req), 32'd1);
        check("bus_hold_addr", addr, prev_addr);
      end
      prev_pend = req && !addr_ok;
      prev_addr = addr;
      if (req && addr_ok) begin n_acc++; infl++; end
      if (data_ok) begin n_dok++; infl--; end
      if (req && addr_ok) check("max_outstanding", 32'(infl <= MAX_OUT), 32'd1);
      if (wb_to_if_bus[32] || id_to_if_bus[32]) begin
        check("valid_on_redirect", 32'(if_to_id_valid), 32'd0);
        exp_pc = wb_to_if_bus[32] ? wb_to_if_bus[31:0] : id_to_if_bus[31:0];
        want_first = 1'b1;
      end else if (if_to_id_valid && id_allowin) begin
        check("id_pc", if_to_id_bus[31:0], exp_pc);
        check("id_inst", if_to_id_bus[63:32], mkinst(exp_pc));
        if (want_first) begin
          first_pc = if_to_id_bus[31:0];
          want_first = 1'b0;
        end
        exp_pc = exp_pc + 32'd4;
        n_id++;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit          allowin;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[6];

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    id_to_if_bus = '0;
    wb_to_if_bus = '0;
    run(3);
    @(negedge clk);
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(if_to_id_valid), 32'd0);
    check("tie_wr", 32'(wr), 32'd0);
    check("tie_size", 32'(size), 32'd2);
    check("tie_wstrb", 32'(wstrb), 32'd0);
    check("tie_wdata", wdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    id_allowin = 1'b1;
    id_to_if_bus = '0;
    wb_to_if_bus = '0;
    addr_delay = 0;
    lat = 1;
    rand_mode = 1'b0;
    first_pc = '0;
    vecs[0] = '{1'b1, 1'b1, 32'h1c000000, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h1c000004, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h1c000008, 1'b1, 32'h1c000000};
    vecs[3] = '{1'b1, 1'b1, 32'h1c00000c, 1'b1, 32'h1c000000};
    vecs[4] = '{1'b1, 1'b1, 32'h1c000010, 1'b1, 32'h1c000004};
    vecs[5] = '{1'b1, 1'b1, 32'h1c000014, 1'b1, 32'h1c000008};

    // 1: back-to-back fetch with a one-cycle memory
    do_reset();
    for (int i = 0; i < 6; i++) begin
      id_allowin = vecs[i].allowin;
      @(negedge clk);
      check($sformatf("t1_req[%0d]", i), 32'(req), 32'(vecs[i].exp_req));
      check($sformatf("t1_addr[%0d]", i), addr, vecs[i].exp_addr);
      check($sformatf("t1_valid[%0d]", i), 32'(if_to_id_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("t1_pc[%0d]", i), if_to_id_bus[31:0], vecs[i].exp_pc);
      @(posedge clk);
      #1;
    end
    run(10);

    // 2: ID stalled, buffer fills to its depth and requests stop
    id_allowin = 1'b0;
    do_reset();
    run(10);
    check("t2_accepts", n_acc, IBUF_D);
    check("t2_responses", n_dok, IBUF_D);
    @(negedge clk);
    check("t2_req_low", 32'(req), 32'd0);
    check("t2_valid", 32'(if_to_id_valid), 32'd1);
    check("t2_head_pc", if_to_id_bus[31:0], RST_PC);
    @(posedge clk);
    #1;
    id_allowin = 1'b1;
    run(12);
    check("t2_drained", 32'(n_id >= IBUF_D), 32'd1);

    // 3: addr_ok held off for three cycles per request
    addr_delay = 3;
    lat = 2;
    do_reset();
    run(40);
    check("t3_accepts", n_acc, 10);
    check("t3_words", n_id, 9);

    // 4: branch with two requests in flight
    addr_delay = 0;
    lat = 4;
    do_reset();
    begin
      bit found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        run(1);
        if (infl == 2) found = 1'b1;
      end
      check("t4_two_inflight", 32'(found), 32'd1);
    end
    first_pc = '0;
    id_to_if_bus = {1'b1, 32'h1c000100};
    run(1);
    id_to_if_bus = '0;
    run(30);
    check("t4_first_pc", first_pc, 32'h1c000100);

    // 5: flush (with simultaneous branch) while a request waits for addr_ok
    addr_delay = 3;
    lat = 1;
    do_reset();
    begin
      bit found = 1'b0;
      for (int k = 0; k < 80 && !found; k++) begin
        @(negedge clk);
        if (req && addr == 32'h1c000010 && !addr_ok && wait_cnt == 0) found = 1'b1;
        @(posedge clk);
        #1;
      end
      check("t5_pending_seen", 32'(found), 32'd1);
    end
    first_pc = '0;
    wb_to_if_bus = {1'b1, 32'h1c008000};
    id_to_if_bus = {1'b1, 32'h1c000200};
    #1;
    check("t5_req_held", 32'(req), 32'd1);
    check("t5_addr_held", addr, 32'h1c000010);
    run(1);
    wb_to_if_bus = '0;
    id_to_if_bus = '0;
    run(30);
    check("t5_first_pc", first_pc, 32'h1c008000);

    // 6: random latencies, stalls and redirects, with one reset mid-run
    rand_mode = 1'b1;
    addr_delay = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      run(1);
      id_allowin = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        int kind = $urandom_range(0, 2);
        logic [31:0] t1 = {$urandom_range(0, 32'h3fffffff), 2'b00};
        logic [31:0] t2 = {$urandom_range(0, 32'h3fffffff), 2'b00};
        id_to_if_bus = {kind != 1, t1};
        wb_to_if_bus = {kind != 0, t2};
      end else begin
        id_to_if_bus = '0;
        wb_to_if_bus = '0;
      end
    end
    id_to_if_bus = '0;
    wb_to_if_bus = '0;
    id_allowin = 1'b1;
    run(20);
    check("t6_progress", 32'(n_id > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
